// File: rtl/plot_arbiter.sv
// Arbitrates the single VGA write port between three player-cell requesters
// (each expanded to a 2x2 pixel burst) and a full-screen background clear sweep.
module plot_arbiter #(
    parameter int         GRID_W    = 80,
    parameter int         GRID_H    = 60,
    parameter logic [5:0] BG_COLOUR = 6'b000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [20:0] req_x,
    input  logic [17:0] req_y,
    input  logic [17:0] req_colour,
    output logic [2:0]  ack,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [5:0]  colour,
    output logic        plot
);

    localparam logic [7:0] X_LAST = 8'(2 * GRID_W - 1);
    localparam logic [6:0] Y_LAST = 7'(2 * GRID_H - 1);
    localparam logic [6:0] GW     = 7'(GRID_W);
    localparam logic [5:0] GH     = 6'(GRID_H);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR} state_t;

    state_t      state_q;
    logic [1:0]  rr_q;
    logic [1:0]  pix_q;
    logic        pending_q;
    logic        inrange_q;
    logic [7:0]  bx_q;
    logic [6:0]  by_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [5:0]  colour_q;
    logic        plot_q;
    logic [2:0]  ack_q;
    logic        busy_q;
    logic        done_q;

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic [6:0]  sel_x;
    logic [5:0]  sel_y;
    logic [5:0]  sel_col;
    logic        sel_in;
    logic [7:0]  clr_nx;
    logic [6:0]  clr_ny;
    logic        clr_nlast;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 3) s = s - 3;
        return 2'(s);
    endfunction

    // Walk the search order backwards so the nearest requester to rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[rr_idx(rr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx(rr_q, k);
            end
        end
        sel_x   = req_x[7*gnt_idx +: 7];
        sel_y   = req_y[6*gnt_idx +: 6];
        sel_col = req_colour[6*gnt_idx +: 6];
        sel_in  = (sel_x < GW) && (sel_y < GH);
    end

    always_comb begin
        clr_nx = x_q + 8'd1;
        clr_ny = y_q;
        if (x_q == X_LAST) begin
            clr_nx = 8'd0;
            clr_ny = y_q + 7'd1;
        end
        clr_nlast = (clr_nx == X_LAST) && (clr_ny == Y_LAST);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= 2'd0;
            pix_q     <= 2'd0;
            pending_q <= 1'b0;
            inrange_q <= 1'b0;
            bx_q      <= 8'd0;
            by_q      <= 7'd0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            colour_q  <= 6'd0;
            plot_q    <= 1'b0;
            ack_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ack_q  <= 3'd0;
            done_q <= 1'b0;
            if (clear_start && state_q != S_CLEAR) pending_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    busy_q <= clear_start;
                    if (pending_q) begin
                        // Clear wins over player requests; first pixel goes out now.
                        state_q   <= S_CLEAR;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        x_q       <= 8'd0;
                        y_q       <= 7'd0;
                        colour_q  <= BG_COLOUR;
                        plot_q    <= 1'b1;
                    end else if (gnt_vld) begin
                        state_q   <= S_DRAW;
                        ack_q     <= 3'b001 << gnt_idx;
                        rr_q      <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
                        bx_q      <= {sel_x, 1'b0};
                        by_q      <= {sel_y, 1'b0};
                        x_q       <= {sel_x, 1'b0};
                        y_q       <= {sel_y, 1'b0};
                        colour_q  <= sel_col;
                        inrange_q <= sel_in;
                        plot_q    <= sel_in;
                        pix_q     <= 2'd1;
                    end
                end
                S_DRAW: begin
                    busy_q <= pending_q | clear_start;
                    // pix_q wraps to 0 after the fourth pixel: one tail cycle, then IDLE.
                    if (pix_q == 2'd0) begin
                        state_q <= S_IDLE;
                        plot_q  <= 1'b0;
                    end else begin
                        x_q    <= bx_q + {7'd0, pix_q[0]};
                        y_q    <= by_q + {6'd0, pix_q[1]};
                        plot_q <= inrange_q;
                        pix_q  <= pix_q + 2'd1;
                    end
                end
                S_CLEAR: begin
                    if (done_q) begin
                        state_q <= S_IDLE;
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        x_q    <= clr_nx;
                        y_q    <= clr_ny;
                        plot_q <= 1'b1;
                        busy_q <= 1'b1;
                        done_q <= clr_nlast;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    plot_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: expected pixels queued at stimulus time, popped as the DUT plots.
module tb_plot_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'd0;
    logic [20:0] req_x = 21'd0;
    logic [17:0] req_y = 18'd0;
    logic [17:0] req_colour = 18'd0;
    logic        clear_start = 1'b0;
    logic [2:0]  ack;
    logic        clear_busy, clear_done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [5:0]  colour;
    logic        plot;

    plot_arbiter dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .ack(ack), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed { logic [7:0] x; logic [6:0] y; logic [5:0] c; } pix_t;
    pix_t exp_q[$];
    pix_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    longint cyc = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic push_cell(input int cx, input int cy, input logic [5:0] c);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{x: 8'(2*cx + (i % 2)), y: 7'(2*cy + (i / 2)), c: c});
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_q.push_back('{x: 8'(xx), y: 7'(yy), c: 6'd0});
    endtask

    task automatic set_player(input int p, input int cx, input int cy, input logic [5:0] c);
        req_x[7*p +: 7]      = 7'(cx);
        req_y[6*p +: 6]      = 6'(cy);
        req_colour[6*p +: 6] = c;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLOCK_50);
            if (ack !== 3'd0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: no ack within 40 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50); #1 reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        bit ok;
        set_player(0, 3, 4, 6'h15);
        set_player(1, 6, 7, 6'h2B);
        set_player(2, 8, 9, 6'h07);
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (plot !== 1'b0 || ack !== 3'd0 || clear_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: plot=%b ack=%b busy=%b want 0/000/0", plot, ack, clear_busy);
            end
        end
        push_cell(3, 4, 6'h15);
        @(posedge CLOCK_50); #1 reset = 1'b0;
        wait_ack(ok);
        req = 3'b000;
        n_cmp++;
        if (ack !== 3'b001) begin
            n_bad++; $display("FAIL reset_first_grant: ack=%b want 001", ack);
        end
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic test_single();
        bit ok;
        set_player(0, 10, 5, 6'b110100);
        push_cell(10, 5, 6'b110100);
        @(posedge CLOCK_50); #1 req = 3'b001;
        wait_ack(ok);
        req = 3'b000;
        n_cmp++;
        if (ack !== 3'b001 || plot !== 1'b1 || x !== 8'd20 || y !== 7'd10) begin
            n_bad++;
            $display("FAIL single_first: ack=%b plot=%b (%0d,%0d) want 001 1 (20,10)", ack, plot, x, y);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (plot !== 1'b1) begin n_bad++; $display("FAIL single_burst: plot=%b want 1", plot); end
        end
        @(negedge CLOCK_50);
        n_cmp++;
        if (plot !== 1'b0) begin n_bad++; $display("FAIL single_gap: plot=%b want 0", plot); end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_round_robin();
        bit ok;
        longint last;
        logic [2:0] want;
        do_reset();
        set_player(0, 1, 2, 6'h11);
        set_player(1, 79, 59, 6'h22);
        set_player(2, 0, 0, 6'h3F);
        push_cell(1, 2, 6'h11);
        push_cell(79, 59, 6'h22);
        push_cell(0, 0, 6'h3F);
        push_cell(1, 2, 6'h11);
        @(posedge CLOCK_50); #1 req = 3'b111;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(ok);
            if (i == 3) req = 3'b000;
            want = 3'b001 << (i % 3);
            n_cmp++;
            if (ack !== want) begin n_bad++; $display("FAIL rr_order[%0d]: ack=%b want %b", i, ack, want); end
            if (i > 0) begin
                n_cmp++;
                if (cyc - last != 5) begin
                    n_bad++; $display("FAIL rr_spacing[%0d]: %0d cycles want 5", i, cyc - last);
                end
            end
            last = cyc;
        end
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic test_clear_during_draw();
        bit ok, done_seen;
        int plots, dones, busy_bad;
        set_player(1, 7, 9, 6'h2A);
        push_cell(7, 9, 6'h2A);
        push_clear();
        @(posedge CLOCK_50); #1 req = 3'b010;
        wait_ack(ok);
        req = 3'b000;
        n_cmp++;
        if (ack !== 3'b010) begin n_bad++; $display("FAIL clr_draw_ack: ack=%b want 010", ack); end
        plots = int'(plot);
        @(posedge CLOCK_50); #1 clear_start = 1'b1;
        @(negedge CLOCK_50); plots += int'(plot);
        @(posedge CLOCK_50); #1 clear_start = 1'b0;
        done_seen = 1'b0; dones = 0; busy_bad = 0;
        for (int i = 0; i < 20000 && !done_seen; i++) begin
            @(negedge CLOCK_50);
            if (plot) plots++;
            if (clear_busy !== 1'b1) busy_bad++;
            if (clear_done) begin
                dones++; done_seen = 1'b1;
                n_cmp++;
                if (x !== 8'd159 || y !== 7'd119) begin
                    n_bad++; $display("FAIL clr_last_pixel: (%0d,%0d) want (159,119)", x, y);
                end
            end
        end
        n_cmp++;
        if (!done_seen) begin n_bad++; $display("FAIL clr_timeout: clear_done never seen"); end
        n_cmp++;
        if (busy_bad != 0) begin n_bad++; $display("FAIL clr_busy: low for %0d cycles want 0", busy_bad); end
        n_cmp++;
        if (plots != 4 + 19200) begin n_bad++; $display("FAIL clr_plot_count: %0d want 19204", plots); end
        @(negedge CLOCK_50);
        n_cmp++;
        if (plot !== 1'b0 || clear_busy !== 1'b0) begin
            n_bad++; $display("FAIL clr_end: plot=%b busy=%b want 0 0", plot, clear_busy);
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_clear_restart();
        bit done_seen, pulsed;
        int plots, dones, extra;
        push_clear();
        @(posedge CLOCK_50); #1 clear_start = 1'b1;
        @(posedge CLOCK_50); #1 clear_start = 1'b0;
        plots = 0; dones = 0; done_seen = 1'b0; pulsed = 1'b0; extra = 0;
        for (int i = 0; i < 20010 && extra < 4; i++) begin
            @(negedge CLOCK_50);
            clear_start = 1'b0;
            if (plot) plots++;
            if (clear_done) begin dones++; done_seen = 1'b1; end
            if (done_seen) extra++;
            if (plots == 5000 && !pulsed) begin clear_start = 1'b1; pulsed = 1'b1; end
        end
        n_cmp++;
        if (plots != 19200) begin n_bad++; $display("FAIL restart_len: %0d plots want 19200", plots); end
        n_cmp++;
        if (dones != 1) begin n_bad++; $display("FAIL restart_done: %0d pulses want 1", dones); end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_out_of_range();
        bit ok;
        do_reset();
        set_player(1, 80, 3, 6'h0F);
        set_player(2, 5, 6, 6'h30);
        @(posedge CLOCK_50); #1 req = 3'b010;
        wait_ack(ok);
        req = 3'b000;
        n_cmp++;
        if (ack !== 3'b010 || plot !== 1'b0) begin
            n_bad++; $display("FAIL oob_ack: ack=%b plot=%b want 010 0", ack, plot);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (plot !== 1'b0) begin n_bad++; $display("FAIL oob_noplot: plot=%b want 0", plot); end
        end
        push_cell(5, 6, 6'h30);
        @(posedge CLOCK_50); #1 req = 3'b111;
        wait_ack(ok);
        req = 3'b000;
        n_cmp++;
        if (ack !== 3'b100) begin n_bad++; $display("FAIL oob_rr_next: ack=%b want 100", ack); end
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic test_reset_abort();
        bit ok;
        set_player(0, 2, 2, 6'h0C);
        push_cell(2, 2, 6'h0C);
        @(posedge CLOCK_50); #1 req = 3'b001;
        wait_ack(ok);
        req = 3'b000;
        reset = 1'b1;
        @(posedge CLOCK_50); #1 exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (plot !== 1'b0 || ack !== 3'd0) begin
                n_bad++; $display("FAIL abort_noplot: plot=%b ack=%b want 0 000", plot, ack);
            end
        end
        @(posedge CLOCK_50); #1 reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLOCK_50);
                if (plot === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++; $display("FAIL pixel_unexpected: plot at (%0d,%0d)", x, y);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (x !== mon_e.x || y !== mon_e.y || colour !== mon_e.c) begin
                            n_bad++;
                            $display("FAIL pixel: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                     x, y, colour, mon_e.x, mon_e.y, mon_e.c);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_clear_during_draw();
        test_clear_restart();
        test_out_of_range();
        test_reset_abort();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL leftover_pixels: %0d expected pixels never plotted", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
